game_over_monitor: RTL and testbench
====================================

GAME_OVER_MONITOR -- requirements
Module: game_over_monitor

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, board columns.
REQ-002 SHALL have parameter LIMIT_H, default 23, first board row that counts as overflow.
REQ-003 SHALL have parameter PIECE_N, default 4, piece window edge length.
REQ-004 SHALL have parameter Y_W, default 5, pos_y and row_addr width.
REQ-005 SHALL have parameter X_W, default 4, pos_x width.
REQ-006 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port start  in  1  request one check; accepted only in IDLE.
REQ-009 SHALL have port clear  in  1  clears sticky game_over.
REQ-010 SHALL have port pos_y  in  Y_W  board row of piece row 0.
REQ-011 SHALL have port pos_x  in  X_W  board column of piece column 0.
REQ-012 SHALL have port float  in  [0:PIECE_N*PIECE_N-1]  piece cells, row-major; float[r*PIECE_N+c] = row r, column c.
REQ-013 SHALL have port row_addr  out  Y_W  board row being read.
REQ-014 SHALL have port row_rd  out  1  read strobe.
REQ-015 SHALL have port row_data  in  BOARD_W  occupancy of the addressed row, valid one cycle after row_rd; bit c = column c.
REQ-016 SHALL have port busy  out  1  check in progress.
REQ-017 SHALL have port done  out  1  one-cycle pulse at end of check.
REQ-018 SHALL have port overflow  out  1  result of last check: a set cell lies at or above LIMIT_H.
REQ-019 SHALL have port collide  out  1  result of last check: a set cell hits an occupied cell or lies at column >= BOARD_W.
REQ-020 SHALL have port game_over  out  1  sticky flag: set whenever done pulses with overflow or collide high.

Function
REQ-021 SHALL latch pos_y, pos_x and float on the accepting start edge; later input changes SHALL not affect the running check.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL use FSM states IDLE -> ISSUE -> EVAL -> (ISSUE for next row | DONE) -> IDLE, with row counter r = 0..PIECE_N-1.
REQ-024 SHALL compute the absolute row as pos_y + r at Y_W+1 bits, with no wrap-around.
REQ-025 In ISSUE, if pos_y + r < LIMIT_H, SHALL drive row_addr = pos_y + r and row_rd = 1; otherwise row_rd = 0 and row_addr = 0.
REQ-026 In EVAL, for a readable row, SHALL set collide if any float cell (r,c)=1 has row_data[pos_x+c]=1 or pos_x+c >= BOARD_W, using X_W+1-bit column arithmetic.
REQ-027 In EVAL, for a row >= LIMIT_H, SHALL set overflow if any float cell in row r is 1; row_data is ignored.
REQ-028 SHALL always scan all PIECE_N rows, with no early exit, so latency is fixed.
REQ-029 With start accepted at edge 0, done SHALL be high for exactly the cycle after edge 2*PIECE_N+1 (edge 9 for PIECE_N=4).
REQ-030 busy SHALL be high from the edge after start through the DONE cycle.
REQ-031 overflow and collide SHALL clear on acceptance of a new start and hold their final values from done until the next start.
REQ-032 When clear and a game-over-setting done occur in the same cycle, game_over SHALL end up 1 (set wins).
REQ-033 An all-zero float SHALL yield overflow=0 and collide=0 regardless of position.

Reset
REQ-034 rst SHALL force IDLE, r=0, and all outputs (busy, done, overflow, collide, game_over, row_rd, row_addr) to 0 on the next edge, including mid-check; no done pulse SHALL follow.
REQ-035 rst SHALL take priority over start and clear in the same cycle.

Structure
REQ-036 Default parameter values and FSM state encodings SHALL live in the shared tetris_pkg.
REQ-037 The per-row evaluation SHALL be a combinational sub-module row_match (inputs: piece row, pos_x, row_data; outputs: hit, wall).

Verification
REQ-038 pos_y=23, float=16'h4000, start -> overflow=1, collide=0, game_over=1, done at cycle 9, no row_rd issued.
REQ-039 pos_y=22, float=16'hF000, empty board -> overflow=0, collide=0; then float=16'hF400 -> overflow=1.
REQ-040 pos_y=5, pos_x=8, float=16'hF000, empty board -> collide=1 (wall); pos_x=6 -> collide=0.
REQ-041 Board row 6 = 10'b0000001000, pos_y=5, pos_x=3, float=16'h0F00 -> collide=1; row_addr sequence 5, 6, 7, 8.
REQ-042 start issued while busy -> ignored; clear pulsed together with an overflow done -> game_over=1; rst asserted at cycle 4 -> all outputs 0 and no done pulse.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the game-over check logic.
// Holds the default board/piece geometry and the monitor FSM state encoding.
package tetris_pkg;

    localparam int BOARD_W_DEF = 10;   // board columns
    localparam int LIMIT_H_DEF = 23;   // first board row that counts as overflow
    localparam int PIECE_N_DEF = 4;    // piece window edge length
    localparam int Y_W_DEF     = 5;    // row coordinate width
    localparam int X_W_DEF     = 4;    // column coordinate width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/game_over_monitor_row_match.sv
// row_match: combinational evaluation of one piece row against one board row.
// Ports:
//   piece_row  in  PIECE_N  piece cells of the row, bit c = piece column c
//   pos_x      in  X_W      board column of piece column 0
//   row_data   in  BOARD_W  board occupancy, bit c = board column c
//   hit        out 1        a set piece cell lands on an occupied board cell
//   wall       out 1        a set piece cell lands at column >= BOARD_W
module row_match
    import tetris_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int PIECE_N = PIECE_N_DEF,
    parameter int X_W     = X_W_DEF
) (
    input  logic [PIECE_N-1:0] piece_row,
    input  logic [X_W-1:0]     pos_x,
    input  logic [BOARD_W-1:0] row_data,
    output logic               hit,
    output logic               wall
);

    logic [X_W:0] col;

    always_comb begin
        hit  = 1'b0;
        wall = 1'b0;
        col  = '0;
        for (int c = 0; c < PIECE_N; c++) begin
            // One extra bit so pos_x + c never wraps back onto the board.
            col = {1'b0, pos_x} + (X_W+1)'(c);
            if (piece_row[c]) begin
                if (int'(col) >= BOARD_W) begin
                    wall = 1'b1;
                end
                // Compare against every board column instead of indexing
                // row_data with the wider column value.
                for (int b = 0; b < BOARD_W; b++) begin
                    if ((int'(col) == b) && row_data[b]) begin
                        hit = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/game_over_monitor.sv
// game_over_monitor: scans the PIECE_N rows under a piece placement, one board
// row read per piece row, and reports overflow / collision plus a sticky
// game_over flag. Latency is fixed: every row is visited.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, clear        check request (IDLE only), clear of sticky game_over
//   pos_y, pos_x, float piece placement and cells (float[r*PIECE_N+c])
//   row_addr, row_rd    board row read port, row_data valid one cycle later
//   row_data            addressed board row occupancy
//   busy, done          check in progress, one-cycle end-of-check pulse
//   overflow, collide   result of the last check
//   game_over           sticky, set when done pulses with a failing result
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | drive read for piece row r (suppressed when row >= LIMIT_H)
// EVAL  | row_data valid; fold row r into overflow/collide
// DONE  | all rows folded; done/game_over update on the next edge
module game_over_monitor
    import tetris_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int LIMIT_H = LIMIT_H_DEF,
    parameter int PIECE_N = PIECE_N_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int X_W     = X_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         clear,
    input  logic [Y_W-1:0]               pos_y,
    input  logic [X_W-1:0]               pos_x,
    input  logic [0:PIECE_N*PIECE_N-1]   float,
    output logic [Y_W-1:0]               row_addr,
    output logic                         row_rd,
    input  logic [BOARD_W-1:0]           row_data,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic                         collide,
    output logic                         game_over
);

    localparam int R_W = (PIECE_N > 1) ? $clog2(PIECE_N) : 1;

    state_t             state;
    state_t             state_next;
    logic [R_W-1:0]     r;
    logic [Y_W-1:0]     pos_y_q;
    logic [X_W-1:0]     pos_x_q;
    logic [PIECE_N-1:0] piece_q [PIECE_N];

    logic               accept;
    logic               last_row;
    logic [Y_W:0]       abs_row;
    logic               readable;
    logic               hit;
    logic               wall;

    // busy stays high through the done cycle, so gating on it keeps a start
    // held across the end of a check from being taken a cycle early.
    assign accept   = (state == IDLE) && !busy && start;
    assign last_row = (r == R_W'(PIECE_N-1));
    assign abs_row  = {1'b0, pos_y_q} + (Y_W+1)'(r);
    assign readable = int'(abs_row) < LIMIT_H;

    row_match #(
        .BOARD_W (BOARD_W),
        .PIECE_N (PIECE_N),
        .X_W     (X_W)
    ) u_row_match (
        .piece_row (piece_q[r]),
        .pos_x     (pos_x_q),
        .row_data  (row_data),
        .hit       (hit),
        .wall      (wall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        row_rd     = 1'b0;
        row_addr   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                row_rd     = readable;
                row_addr   = readable ? abs_row[Y_W-1:0] : '0;
                state_next = EVAL;
            end
            EVAL: begin
                state_next = last_row ? DONE : ISSUE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r         <= '0;
            pos_y_q   <= '0;
            pos_x_q   <= '0;
            for (int i = 0; i < PIECE_N; i++) begin
                piece_q[i] <= '0;
            end
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            collide   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            busy <= (state_next != IDLE) || (state == DONE);
            done <= (state == DONE);

            if (accept) begin
                r        <= '0;
                pos_y_q  <= pos_y;
                pos_x_q  <= pos_x;
                for (int rr = 0; rr < PIECE_N; rr++) begin
                    for (int cc = 0; cc < PIECE_N; cc++) begin
                        piece_q[rr][cc] <= float[rr*PIECE_N + cc];
                    end
                end
                overflow <= 1'b0;
                collide  <= 1'b0;
            end

            if (state == EVAL) begin
                if (readable) begin
                    collide <= collide | hit | wall;
                end else begin
                    overflow <= overflow | (|piece_q[r]);
                end
                r <= last_row ? '0 : r + 1'b1;
            end

            // A failing result set on this edge, or still showing on done,
            // outranks a simultaneous clear.
            if ((state == DONE) && (overflow || collide)) begin
                game_over <= 1'b1;
            end else if (clear && !(done && (overflow || collide))) begin
                game_over <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_game_over_monitor.sv
module tb_game_over_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear;
    logic [4:0]  pos_y;
    logic [3:0]  pos_x;
    logic [0:15] float_in;
    logic [4:0]  row_addr;
    logic        row_rd;
    logic [9:0]  row_data = '0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        collide;
    logic        game_over;

    int          n_applied = 0;
    int          n_miss    = 0;
    logic [9:0]  board [32];
    int          done_cyc;
    int          n_done;
    int          n_rd;
    logic [4:0]  addr_log [8];

    typedef struct {
        logic [4:0]  py;
        logic [3:0]  px;
        logic [15:0] fl;
        logic [4:0]  brow;
        logic [9:0]  bval;
        logic        eo;
        logic        ec;
        int          nrd;
    } vec_t;

    vec_t vecs [12];

    game_over_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .pos_y     (pos_y),
        .pos_x     (pos_x),
        .float     (float_in),
        .row_addr  (row_addr),
        .row_rd    (row_rd),
        .row_data  (row_data),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .collide   (collide),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // Board memory: one-cycle read latency.
    always @(posedge clk) begin
        if (row_rd) row_data <= board[row_addr];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_applied++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_board;
        for (int i = 0; i < 32; i++) board[i] = '0;
    endtask

    // Presents a request and returns #1 after the accepting edge (edge 0).
    task automatic start_check(input logic [4:0] py, input logic [3:0] px, input logic [15:0] fl);
        done_cyc = -1;
        n_done   = 0;
        n_rd     = 0;
        pos_y    = py;
        pos_x    = px;
        float_in = fl;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Records what is visible in the cycle after edge cyc.
    task automatic track(input int cyc);
        if (row_rd) begin
            if (n_rd < 8) addr_log[n_rd] = row_addr;
            n_rd++;
        end
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
    endtask

    initial begin
        //            py     px    float     brow   bval         ovf   col   reads
        vecs[0]  = '{5'd23, 4'd0, 16'h4000, 5'd0,  10'h000, 1'b1, 1'b0, 0};
        vecs[1]  = '{5'd22, 4'd0, 16'hF000, 5'd0,  10'h000, 1'b0, 1'b0, 1};
        vecs[2]  = '{5'd22, 4'd0, 16'hF400, 5'd0,  10'h000, 1'b1, 1'b0, 1};
        vecs[3]  = '{5'd5,  4'd8, 16'hF000, 5'd0,  10'h000, 1'b0, 1'b1, 4};
        vecs[4]  = '{5'd5,  4'd6, 16'hF000, 5'd0,  10'h000, 1'b0, 1'b0, 4};
        vecs[5]  = '{5'd5,  4'd3, 16'h0F00, 5'd6,  10'h008, 1'b0, 1'b1, 4};
        vecs[6]  = '{5'd5,  4'd3, 16'h0000, 5'd6,  10'h008, 1'b0, 1'b0, 4};
        vecs[7]  = '{5'd30, 4'd9, 16'h0000, 5'd0,  10'h000, 1'b0, 1'b0, 0};
        vecs[8]  = '{5'd0,  4'd0, 16'h8000, 5'd0,  10'h001, 1'b0, 1'b1, 4};
        vecs[9]  = '{5'd20, 4'd7, 16'h0001, 5'd0,  10'h000, 1'b1, 1'b0, 3};
        vecs[10] = '{5'd19, 4'd7, 16'h0001, 5'd0,  10'h000, 1'b0, 1'b1, 4};
        vecs[11] = '{5'd22, 4'd6, 16'h8001, 5'd0,  10'h000, 1'b1, 1'b0, 1};

        rst      = 1'b1;
        start    = 1'b0;
        clear    = 1'b0;
        pos_y    = '0;
        pos_x    = '0;
        float_in = '0;
        clear_board();
        tick();
        tick();
        check("reset_state", {busy, done, overflow, collide, game_over, row_rd, row_addr}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            clear_board();
            board[vecs[i].brow] = vecs[i].bval;
            clear = 1'b1;
            tick();
            clear = 1'b0;
            check($sformatf("v%0d_go_cleared", i), game_over, 0);
            start_check(vecs[i].py, vecs[i].px, vecs[i].fl);
            for (int cyc = 0; cyc < 12; cyc++) begin
                track(cyc);
                tick();
            end
            check($sformatf("v%0d_overflow", i), overflow, vecs[i].eo);
            check($sformatf("v%0d_collide", i), collide, vecs[i].ec);
            check($sformatf("v%0d_game_over", i), game_over, vecs[i].eo | vecs[i].ec);
            check($sformatf("v%0d_done_cycle", i), done_cyc, 9);
            check($sformatf("v%0d_done_pulses", i), n_done, 1);
            check($sformatf("v%0d_reads", i), n_rd, vecs[i].nrd);
            for (int k = 0; k < n_rd && k < 8; k++) begin
                check($sformatf("v%0d_addr%0d", i, k), addr_log[k], vecs[i].py + 5'(k));
            end
        end

        // start held while busy, with inputs changed after acceptance
        clear_board();
        start_check(5'd23, 4'd0, 16'h4000);
        start    = 1'b1;
        pos_y    = 5'd0;
        float_in = 16'h0000;
        for (int cyc = 0; cyc < 12; cyc++) begin
            track(cyc);
            if (cyc == 0) check("busy_after_start", busy, 1);
            if (cyc == 9) check("busy_in_done", busy, 1);
            if (cyc == 10) check("busy_after_done", busy, 0);
            if (cyc == 7) start = 1'b0;
            tick();
        end
        check("busy_start_done_cycle", done_cyc, 9);
        check("busy_start_done_pulses", n_done, 1);
        check("busy_start_overflow", overflow, 1);
        check("busy_start_collide", collide, 0);
        check("busy_start_reads", n_rd, 0);

        // clear held across the game-over-setting done
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("pre_clear_go", game_over, 0);
        start_check(5'd23, 4'd0, 16'h4000);
        for (int cyc = 0; cyc < 12; cyc++) begin
            track(cyc);
            if (cyc == 8) clear = 1'b1;
            if (cyc == 10) begin
                check("clear_vs_set_go", game_over, 1);
                clear = 1'b0;
            end
            tick();
        end
        check("clear_vs_set_done", done_cyc, 9);
        check("clear_vs_set_go_hold", game_over, 1);

        // reset mid-check, together with a start request
        start_check(5'd23, 4'd0, 16'h4000);
        for (int cyc = 0; cyc < 15; cyc++) begin
            track(cyc);
            if (cyc == 3) begin
                check("pre_rst_overflow", overflow, 1);
                rst   = 1'b1;
                start = 1'b1;
            end
            if (cyc == 4) begin
                check("mid_rst_outputs", {busy, done, overflow, collide, game_over, row_rd, row_addr}, 0);
                rst   = 1'b0;
                start = 1'b0;
            end
            tick();
        end
        check("mid_rst_no_done", n_done, 0);
        check("mid_rst_idle", {busy, overflow, game_over}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
